// File: rtl/uart_tx_pkg.sv
// Shared encodings for the UART transmit frame controller.
//   state_t      : frame sequencing states (3-bit encoding)
//   MUX_*        : TX line source select, decoded from registered state only
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // IDLE and STOP both drive a mark (1), so they share MUX_STOP.
    localparam logic [1:0] MUX_START = 2'b00;
    localparam logic [1:0] MUX_STOP  = 2'b01;
    localparam logic [1:0] MUX_DATA  = 2'b10;
    localparam logic [1:0] MUX_PAR   = 2'b11;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator for one UART frame.
// Ports:
//   data     in   DATA_WIDTH  latched frame data
//   par_typ  in   1           0 = even parity, 1 = odd parity
//   par_bit  out  1           parity bit to place on the line
module uart_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller. Latches a host byte plus parity config,
// sequences an external serializer, and owns the TX line mux.
// Ports:
//   CLK, RST    clock (rising edge) / async active-low reset
//   P_DATA      byte to send, sampled on acceptance
//   Data_Valid  send request, accepted in IDLE or STOP
//   PAR_EN      parity enable, sampled on acceptance
//   PAR_TYP     0 = even, 1 = odd, sampled on acceptance
//   ser_done    serializer has shifted all bits
//   ser_data    serializer bit stream
//   ser_load    one-cycle load pulse to the serializer (START)
//   ser_pdata   latched frame data for the serializer
//   ser_en      serializer shift enable (DATA)
//   TX_OUT      serial line, idle high
//   busy        frame in progress
//
// state  | meaning
// IDLE   | line idle high, waiting for Data_Valid
// START  | start bit (0), serializer load pulse
// DATA   | line follows serializer until ser_done
// PARITY | parity bit from latched data/type
// STOP   | stop bit (1); Data_Valid here starts the next frame directly
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_load,
    output logic [DATA_WIDTH-1:0] ser_pdata,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  busy
);

    state_t     state;
    logic [1:0] tx_sel;
    logic       par_en_q;
    logic       par_typ_q;
    logic       par_bit;
    logic       tx_line;

    uart_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data    (ser_pdata),
        .par_typ (par_typ_q),
        .par_bit (par_bit)
    );

    // Outputs and line select are registered alongside the state so the
    // line never depends combinationally on Data_Valid.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            tx_sel    <= MUX_STOP;
            ser_load  <= 1'b0;
            ser_en    <= 1'b0;
            busy      <= 1'b0;
            ser_pdata <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            ser_load <= 1'b0;
            case (state)
                ST_IDLE, ST_STOP: begin
                    if (Data_Valid) begin
                        state     <= ST_START;
                        tx_sel    <= MUX_START;
                        ser_load  <= 1'b1;
                        ser_en    <= 1'b0;
                        busy      <= 1'b1;
                        ser_pdata <= P_DATA;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                    end else begin
                        state  <= ST_IDLE;
                        tx_sel <= MUX_STOP;
                        ser_en <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                ST_START: begin
                    state  <= ST_DATA;
                    tx_sel <= MUX_DATA;
                    ser_en <= 1'b1;
                end
                ST_DATA: begin
                    if (ser_done) begin
                        ser_en <= 1'b0;
                        if (par_en_q) begin
                            state  <= ST_PARITY;
                            tx_sel <= MUX_PAR;
                        end else begin
                            state  <= ST_STOP;
                            tx_sel <= MUX_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    state  <= ST_STOP;
                    tx_sel <= MUX_STOP;
                end
                default: begin
                    state  <= ST_IDLE;
                    tx_sel <= MUX_STOP;
                    ser_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        tx_line = 1'b1;
        case (tx_sel)
            MUX_START: tx_line = 1'b0;
            MUX_DATA:  tx_line = ser_data;
            MUX_PAR:   tx_line = par_bit;
            default:   tx_line = 1'b1;
        endcase
    end

    assign TX_OUT = tx_line;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl with a behavioural serializer and a
// scoreboard queue of expected line bits, checked every busy cycle.
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       ser_done;
    logic       ser_data;
    logic       ser_load;
    logic [7:0] ser_pdata;
    logic       ser_en;
    logic       TX_OUT;
    logic       busy;

    int errors = 0;
    int checks = 0;
    bit exp_q[$];
    int busy_cycles;

    always #5 CLK = ~CLK;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_done   (ser_done),
        .ser_data   (ser_data),
        .ser_load   (ser_load),
        .ser_pdata  (ser_pdata),
        .ser_en     (ser_en),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    // Behavioural serializer: load, shift LSB first, done on the last bit.
    logic [7:0] sh;
    logic [3:0] cnt;
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sh  <= 8'h00;
            cnt <= 4'd0;
        end else if (ser_load) begin
            sh  <= ser_pdata;
            cnt <= 4'd0;
        end else if (ser_en) begin
            sh  <= sh >> 1;
            cnt <= cnt + 4'd1;
        end
    end
    assign ser_data = sh[0];
    assign ser_done = (cnt == 4'd7);

    // Scoreboard monitor: every busy cycle must match the next expected bit.
    always @(negedge CLK) begin
        if (RST && busy) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL extra_bit: observed busy with tx=%b, required no frame pending", TX_OUT);
            end
            if (exp_q.size() != 0) begin
                bit e;
                e = exp_q.pop_front();
                checks++;
                assert (TX_OUT === e) else begin
                    errors++;
                    $error("FAIL tx_bit: observed=%b required=%b", TX_OUT, e);
                end
            end
        end
    end

    task automatic push_frame(input logic [7:0] d, input logic pen, input logic ptyp);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (pen) exp_q.push_back((^d) ^ ptyp);
        exp_q.push_back(1'b1);
    endtask

    task automatic count_busy();
        busy_cycles = 0;
        while (busy && busy_cycles < 60) begin
            busy_cycles++;
            @(negedge CLK);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pen, input logic ptyp, input int len);
        @(negedge CLK);
        P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Data_Valid = 1'b1;
        push_frame(d, pen, ptyp);
        @(negedge CLK);
        Data_Valid = 1'b0;
        count_busy();
        checks++;
        assert (busy_cycles === len) else begin
            errors++;
            $error("FAIL frame_len: observed=%0d required=%0d", busy_cycles, len);
        end
        checks++;
        assert (exp_q.size() === 0) else begin
            errors++;
            $error("FAIL frame_done: observed pending=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        // 1. reset and idle
        #12 RST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            checks++;
            assert ({TX_OUT, busy, ser_en} === 3'b100) else begin
                errors++;
                $error("FAIL idle: observed tx/busy/en=%b required=100", {TX_OUT, busy, ser_en});
            end
        end

        // 2. no parity, 10-cycle frame
        send(8'hA5, 1'b0, 1'b0, 10);
        // 3. even then odd parity, 11-cycle frames
        send(8'hA5, 1'b1, 1'b0, 11);
        send(8'hA5, 1'b1, 1'b1, 11);

        // 4. back-to-back via Data_Valid held through STOP
        @(negedge CLK);
        P_DATA = 8'h3C; PAR_EN = 1'b0; Data_Valid = 1'b1;
        push_frame(8'h3C, 1'b0, 1'b0);
        @(negedge CLK);
        P_DATA = 8'hC3;
        push_frame(8'hC3, 1'b0, 1'b0);
        busy_cycles = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (busy) busy_cycles++;
        end
        Data_Valid = 1'b0;
        @(negedge CLK);
        begin
            int first_part;
            first_part = busy_cycles;
            count_busy();
            busy_cycles += first_part;
        end
        checks++;
        assert (busy_cycles === 20) else begin
            errors++;
            $error("FAIL b2b_busy: observed=%0d required=20", busy_cycles);
        end
        checks++;
        assert (exp_q.size() === 0) else begin
            errors++;
            $error("FAIL b2b_done: observed pending=%0d required=0", exp_q.size());
        end

        // 5. input changes during DATA are ignored
        @(negedge CLK);
        P_DATA = 8'h5A; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
        push_frame(8'h5A, 1'b1, 1'b1);
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (2) @(negedge CLK);
        P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        busy_cycles = 3;
        begin
            int first_part;
            first_part = busy_cycles;
            count_busy();
            busy_cycles += first_part;
        end
        checks++;
        assert (busy_cycles === 11) else begin
            errors++;
            $error("FAIL ignore_len: observed=%0d required=11", busy_cycles);
        end
        repeat (3) @(negedge CLK);
        checks++;
        assert (busy === 1'b0 && exp_q.size() === 0) else begin
            errors++;
            $error("FAIL no_extra: observed busy=%b pending=%0d required busy=0 pending=0", busy, exp_q.size());
        end

        // 6. reset in mid-DATA aborts asynchronously
        @(negedge CLK);
        P_DATA = 8'h96; PAR_EN = 1'b0; Data_Valid = 1'b1;
        push_frame(8'h96, 1'b0, 1'b0);
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (4) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        checks++;
        assert ({TX_OUT, busy, ser_en} === 3'b100) else begin
            errors++;
            $error("FAIL async_rst: observed tx/busy/en=%b required=100", {TX_OUT, busy, ser_en});
        end
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b1;
        send(8'h96, 1'b1, 1'b0, 11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
